// File: rtl/intc_bamse.sv
// intc_bamse: eight-line edge-detecting interrupt controller for the BAMSE PicoBlaze.
// Latency: source rise -> PEND at next edge -> interrupt one edge later; reads are combinational.
// Backpressure: none; PicoBlaze handshakes via interrupt/interrupt_ack and an EOI write.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   irq_src[7:0]      peripheral interrupt levels (bit 0 = timer, highest priority)
//   address/data_in   port-mapped bus, registers at ADDR..ADDR+3 (PEND, MASK, VEC, CTRL)
//   ren/wen           read/write strobes; data_out is 0 when not addressed (OR-able)
//   interrupt         to PicoBlaze; interrupt_ack from PicoBlaze
module intc_bamse #(
  parameter logic [7:0] ADDR = 8'h10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_src,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       ren,
  input  logic       wen,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] irq_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic       gen_q, gen_d;
  logic [2:0] vec_q, vec_d;

  logic       hit;
  logic       wr_pend, wr_mask, wr_vec, wr_ctrl;
  logic [7:0] w1c;
  logic [7:0] rise;
  logic [7:0] active;
  logic       req;
  logic [2:0] idx;
  logic       latch_idx;
  logic       in_service;

  // Block is 4-aligned, so the upper six address bits select the window.
  assign hit     = (address[7:2] == ADDR[7:2]);
  assign wr_pend = wen & hit & (address[1:0] == 2'd0);
  assign wr_mask = wen & hit & (address[1:0] == 2'd1);
  assign wr_vec  = wen & hit & (address[1:0] == 2'd2);
  assign wr_ctrl = wen & hit & (address[1:0] == 2'd3);

  assign w1c  = wr_pend ? data_in : 8'h00;
  assign rise = irq_src & ~irq_q;

  // A rise in the same cycle as a W1C wins, so OR the rise in last.
  assign pend_d = (pend_q & ~w1c) | rise;
  assign mask_d = wr_mask ? data_in : mask_q;
  assign gen_d  = wr_ctrl ? data_in[0] : gen_q;

  assign active = pend_q & mask_q;
  assign req    = gen_q & (|active);

  // Lowest set bit wins: scan downward so the last hit is the lowest index.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) idx = i[2:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_idx = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d   = S_ASSERT;
          latch_idx = 1'b1;
        end
      end
      S_ASSERT: begin
        // Ack outranks a simultaneous withdrawal of the request.
        if (interrupt_ack)   state_d = S_SERVICE;
        else if (!req)       state_d = S_IDLE;
      end
      S_SERVICE: begin
        if (wr_vec) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vec_d = latch_idx ? idx : vec_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      irq_q   <= 8'h00;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      gen_q   <= 1'b0;
      vec_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_src;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      gen_q   <= gen_d;
      vec_q   <= vec_d;
    end
  end

  assign interrupt  = (state_q == S_ASSERT);
  assign in_service = (state_q == S_SERVICE);

  always_comb begin
    data_out = 8'h00;
    if (ren && hit) begin
      case (address[1:0])
        2'd0:    data_out = pend_q;
        2'd1:    data_out = mask_q;
        2'd2:    data_out = {in_service, 4'b0000, vec_q};
        default: data_out = {7'b0000000, gen_q};
      endcase
    end
  end

endmodule
